// File: rtl/instr_encoder_pkg.sv
// Shared instruction constants for the encoder, CPU decoder and ALU control.
// Holds the descriptor kind codes, opcode/funct fields and word-assembly helpers.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    KIND_ADD  = 3'd0,
    KIND_SUB  = 3'd1,
    KIND_AND  = 3'd2,
    KIND_OR   = 3'd3,
    KIND_SLT  = 3'd4,
    KIND_ADDI = 3'd5,
    KIND_BEQ  = 3'd6,
    KIND_SLTI = 3'd7
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_SLTI  = 6'h0A;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational assembly of one MIPS word from a symbolic descriptor.
// kind_ok drops only when the kind is not one of the known codes (e.g. X in simulation).
module instr_word_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        kind_ok
);

  always_comb begin
    word    = '0;
    kind_ok = 1'b1;
    case (kind)
      KIND_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
      KIND_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
      KIND_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
      KIND_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
      KIND_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
      KIND_ADDI: word = i_word(OP_ADDI, rs, rt, imm);
      KIND_BEQ:  word = i_word(OP_BEQ, rs, rt, imm);
      KIND_SLTI: word = i_word(OP_SLTI, rs, rt, imm);
      default:   kind_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming instruction loader: accepts descriptors, encodes them and writes
// consecutive instruction-memory words through a single registered write stage.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [2:0]        kind_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [31:0]       wdata_o,
  input  logic              mem_ready_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              err_o
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_e              state_reg;
  logic                we_reg;
  logic [ADDR_W-1:0]   waddr_reg;
  logic [31:0]         wdata_reg;
  logic [ADDR_W:0]     count_reg;
  logic                full_reg;
  logic                err_reg;
  logic [31:0]         word_next;
  logic                kind_ok;
  logic                accept;

  instr_word_pack u_pack (
    .kind    (kind_i),
    .rs      (rs_i),
    .rt      (rt_i),
    .rd      (rd_i),
    .imm     (imm_i),
    .word    (word_next),
    .kind_ok (kind_ok)
  );

  // A pending write sitting on the last free slot blocks new accepts so that
  // slot cannot be booked twice.
  assign ready_o = !full_reg && (!we_reg || (mem_ready_i && count_reg != LAST_CNT));
  assign accept  = valid_i && ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      waddr_reg <= BASE_A;
      wdata_reg <= '0;
      count_reg <= '0;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else if (flush_i) begin
      state_reg <= ST_IDLE;
      we_reg    <= 1'b0;
      waddr_reg <= BASE_A;
      count_reg <= '0;
      full_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      if (accept && !kind_ok)
        err_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            wdata_reg <= word_next;
            we_reg    <= 1'b1;
            state_reg <= ST_PEND;
          end
        end
        ST_PEND: begin
          if (mem_ready_i) begin
            count_reg <= count_reg + 1'b1;
            // The final commit leaves the address on the last slot instead of wrapping.
            if (count_reg == LAST_CNT) begin
              we_reg    <= 1'b0;
              full_reg  <= 1'b1;
              state_reg <= ST_FULL;
            end else begin
              waddr_reg <= waddr_reg + 1'b1;
              if (accept) begin
                wdata_reg <= word_next;
              end else begin
                we_reg    <= 1'b0;
                state_reg <= ST_IDLE;
              end
            end
          end
        end
        ST_FULL: ;
        default: begin
          we_reg    <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign we_o    = we_reg;
  assign waddr_o = waddr_reg;
  assign wdata_o = wdata_reg;
  assign count_o = count_reg;
  assign full_o  = full_reg;
  assign err_o   = err_reg;

endmodule
